// File: rtl/pwm_pkg.sv
// Shared types and constants for the PWM timebase slice.
// PWM_DITHER_EN widens compare words by the dither fraction bits.
package pwm_pkg;

`ifdef PWM_DITHER_EN
    localparam bit DITHER_EN = 1'b1;
`else
    localparam bit DITHER_EN = 1'b0;
`endif

    localparam int PWM_WIDTH  = 17;
    localparam int PWM_HRBITS = 3;
    localparam int PWM_DBITS  = 4;

    function automatic int calc_tbw(input int width, input int hrbits);
        return width - hrbits - 1;
    endfunction

    localparam int PWM_TBW = calc_tbw(PWM_WIDTH, PWM_HRBITS);
    localparam int PWM_FW  = DITHER_EN ? PWM_DBITS : 0;
    localparam int PWM_CW  = PWM_WIDTH - 1 + PWM_FW;

    // Sized by the package defaults; the top keeps its parameters at these values.
    typedef struct packed {
        logic [PWM_TBW-1:0] top;
        logic [PWM_CW-1:0]  cmph;
        logic [PWM_CW-1:0]  cmpl;
    } cmp_set_t;

    localparam logic [PWM_TBW-1:0] TOP_RST = '1;
    localparam cmp_set_t SET_RST = '{top: TOP_RST, cmph: '0, cmpl: '0};

endpackage

// File: rtl/pwm_dither_acc.sv
// Per-word dither accumulator: adds the fraction at each wrap and bumps the
// output word by one fine LSB on carry, saturating at {top, all-ones}.
module pwm_dither_acc #(
    parameter  int TBW    = 13,
    parameter  int HRBITS = 3,
    parameter  int DBITS  = 4,
    localparam int OW     = TBW + HRBITS,
    localparam int CW     = OW + DBITS
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           wrap,
    input  logic           apply,
    input  logic [CW-1:0]  new_word,
    input  logic [CW-1:0]  cur_word,
    input  logic [TBW-1:0] top,
    output logic [OW-1:0]  cmp_out
);

    logic [DBITS-1:0] acc_q, acc_d;
    logic [OW-1:0]    out_q, out_d;
    logic [DBITS:0]   sum;
    logic [OW-1:0]    base;
    logic [OW-1:0]    ceil;

    always_comb begin
        sum   = {1'b0, acc_q} + {1'b0, cur_word[DBITS-1:0]};
        base  = cur_word[CW-1:DBITS];
        ceil  = {top, {HRBITS{1'b1}}};
        acc_d = acc_q;
        out_d = out_q;
        if (apply) begin
            // A fresh set starts its dither sequence from zero.
            acc_d = '0;
            out_d = new_word[CW-1:DBITS];
        end else if (wrap) begin
            acc_d = sum[DBITS-1:0];
            out_d = (sum[DBITS] && (base < ceil)) ? base + 1'b1 : base;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
            out_q <= '0;
        end else begin
            acc_q <= acc_d;
            out_q <= out_d;
        end
    end

    assign cmp_out = out_q;

endmodule

// File: rtl/pwm_timebase.sv
// Coarse PWM timebase with a one-deep staged compare set applied at the wrap.
// Define PWM_DITHER_EN to add per-word fractional dither accumulators.
module pwm_timebase
    import pwm_pkg::*;
#(
    parameter  int WIDTH  = PWM_WIDTH,
    parameter  int HRBITS = PWM_HRBITS,
    parameter  int DBITS  = PWM_DBITS,
    localparam int TBW    = calc_tbw(WIDTH, HRBITS),
    localparam int CW     = WIDTH - 1 + (DITHER_EN ? DBITS : 0)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             upd_valid,
    output logic             upd_ready,
    input  logic [TBW-1:0]   upd_top,
    input  logic [CW-1:0]    upd_cmpH,
    input  logic [CW-1:0]    upd_cmpL,
    output logic [TBW-1:0]   tb,
    output logic [WIDTH-2:0] cmpH,
    output logic [WIDTH-2:0] cmpL,
    output logic             period_start
);

    logic [TBW-1:0] tb_q, tb_d;
    cmp_set_t       act_q, act_d;
    cmp_set_t       stg_q, stg_d;
    logic           stg_full_q, stg_full_d;
    logic           pstart_q, pstart_d;
    logic           wrap;
    logic           xfer;
    logic           apply;

    // Coarse field sits above the fine (and fraction) bits; the fine bits survive clamping.
    function automatic logic [CW-1:0] clamp_word(input logic [CW-1:0] w,
                                                 input logic [TBW-1:0] top);
        logic [CW-1:0] r;
        r = w;
        if (w[CW-1 -: TBW] > top) begin
            r[CW-1 -: TBW] = top;
        end
        return r;
    endfunction

    assign wrap  = en && (tb_q == act_q.top);
    assign xfer  = upd_valid && !stg_full_q;
    assign apply = wrap && stg_full_q;

    always_comb begin
        tb_d       = tb_q;
        act_d      = act_q;
        stg_d      = stg_q;
        stg_full_d = stg_full_q;
        pstart_d   = wrap;

        if (en) begin
            tb_d = wrap ? '0 : tb_q + 1'b1;
        end

        if (apply) begin
            act_d.top  = stg_q.top;
            act_d.cmph = clamp_word(stg_q.cmph, stg_q.top);
            act_d.cmpl = clamp_word(stg_q.cmpl, stg_q.top);
            stg_full_d = 1'b0;
        end

        // xfer needs an empty stage and apply a full one, so a same-cycle
        // transfer is held for the following wrap.
        if (xfer) begin
            stg_d.top  = upd_top;
            stg_d.cmph = upd_cmpH;
            stg_d.cmpl = upd_cmpL;
            stg_full_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tb_q       <= '0;
            act_q      <= SET_RST;
            stg_q      <= SET_RST;
            stg_full_q <= 1'b0;
            pstart_q   <= 1'b0;
        end else begin
            tb_q       <= tb_d;
            act_q      <= act_d;
            stg_q      <= stg_d;
            stg_full_q <= stg_full_d;
            pstart_q   <= pstart_d;
        end
    end

    assign tb           = tb_q;
    assign upd_ready    = ~stg_full_q;
    assign period_start = pstart_q;

`ifdef PWM_DITHER_EN
    pwm_dither_acc #(
        .TBW    (TBW),
        .HRBITS (HRBITS),
        .DBITS  (DBITS)
    ) u_dither_h (
        .clk      (clk),
        .rst      (rst),
        .wrap     (wrap),
        .apply    (apply),
        .new_word (act_d.cmph),
        .cur_word (act_q.cmph),
        .top      (act_q.top),
        .cmp_out  (cmpH)
    );

    pwm_dither_acc #(
        .TBW    (TBW),
        .HRBITS (HRBITS),
        .DBITS  (DBITS)
    ) u_dither_l (
        .clk      (clk),
        .rst      (rst),
        .wrap     (wrap),
        .apply    (apply),
        .new_word (act_d.cmpl),
        .cur_word (act_q.cmpl),
        .top      (act_q.top),
        .cmp_out  (cmpL)
    );
`else
    assign cmpH = act_q.cmph;
    assign cmpL = act_q.cmpl;
`endif

endmodule
